debounced_updown_counter: RTL and testbench

Parametrised successor to the single-button debounced counter. It debounces NUM_BTNS raw pushbutton inputs with per-channel stable-time filters. Each channel produces a clean level plus one-cycle press/release pulses. Channel 0 increments and channel 1 decrements a CNT_WIDTH-bit counter, which either wraps or saturates. Sits between board pushbuttons and user logic such as the LED display.

---
 rtl/debounce_pkg.sv | 36 +++
 rtl/debounce_channel.sv | 73 +++++++
 rtl/debounced_updown_counter.sv | 95 +++++++++
 tb/tb_debounced_updown_counter.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// ---------------------------------------------------------------------------
// debounce_pkg
// Shared definitions for the pushbutton debouncer and up/down counter.
//   BTN_ACTIVE_LOW / BTN_ACTIVE_HIGH : raw pin polarity selectors
//   STABLE_CYCLES_12MHZ              : default stable time for the 12 MHz board
//                                      (40 ms at 12 MHz)
//   clog2()                          : ceiling log2, usable in constant context
//   step_e                           : counter step decoded from the press pulses
// ---------------------------------------------------------------------------
package debounce_pkg;

  localparam bit BTN_ACTIVE_LOW  = 1'b1;
  localparam bit BTN_ACTIVE_HIGH = 1'b0;

  localparam int unsigned STABLE_CYCLES_12MHZ = 480000;

  // Number of bits needed to hold values 0 .. value-1.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    int unsigned v;
    result = 0;
    v      = (value > 0) ? value - 1 : 0;
    while (v > 0) begin
      result = result + 1;
      v      = v >> 1;
    end
    return result;
  endfunction

  typedef enum logic [1:0] {
    STEP_HOLD,
    STEP_UP,
    STEP_DOWN
  } step_e;

endpackage

// File: rtl/debounce_channel.sv
// ---------------------------------------------------------------------------
// debounce_channel
// Debounces one raw pushbutton input.
//   clk         : system clock, rising edge
//   rst         : synchronous, active-high reset
//   btn_raw     : raw, asynchronous, bouncing pin
//   btn_level   : debounced level, 1 = pressed regardless of ACTIVE_LOW
//   btn_press   : one-cycle pulse in the cycle btn_level rises
//   btn_release : one-cycle pulse in the cycle btn_level falls
// A clean edge on btn_raw reaches btn_level STABLE_CYCLES+2 rising edges after
// it is first sampled: two synchroniser stages plus STABLE_CYCLES filter cycles.
// ---------------------------------------------------------------------------
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_12MHZ,
  parameter bit          ACTIVE_LOW    = BTN_ACTIVE_LOW
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release
);

  localparam int unsigned        CNT_W    = clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  // Synchroniser carries the raw pin, so it idles at the released pin level.
  localparam logic               RAW_IDLE = ACTIVE_LOW;

  logic             sync_q1;
  logic             sync_q2;
  logic             btn_s;
  logic [CNT_W-1:0] stable_cnt;

  // Normalised synchronised input: 1 = pressed.
  assign btn_s = sync_q2 ^ ACTIVE_LOW;

  // NOTE: every flop here is assigned with <= so all of them see the values
  // from before the edge; blocking = would let sync_q2 pick up this cycle's
  // sync_q1 and collapse the two-stage synchroniser into one.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q1     <= RAW_IDLE;
      sync_q2     <= RAW_IDLE;
      stable_cnt  <= '0;
      btn_level   <= 1'b0;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
    end else begin
      sync_q1     <= btn_raw;
      sync_q2     <= sync_q1;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;

      if (btn_s == btn_level) begin
        // Input agrees with the accepted level (or bounced back): restart.
        stable_cnt <= '0;
      end else if (stable_cnt == CNT_LAST) begin
        // Disagreed for STABLE_CYCLES consecutive cycles: accept the new level
        // and flag the edge in the same cycle.
        btn_level   <= btn_s;
        stable_cnt  <= '0;
        btn_press   <= btn_s;
        btn_release <= ~btn_s;
      end else begin
        stable_cnt <= stable_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/debounced_updown_counter.sv
// ---------------------------------------------------------------------------
// debounced_updown_counter
// Debounces NUM_BTNS (>= 2) pushbuttons and drives an up/down counter from
// channel 0 (increment) and channel 1 (decrement). Channels 2+ only provide
// level and pulses.
//   clk         : system clock, rising edge
//   rst         : synchronous, active-high reset
//   btn_raw     : raw, asynchronous, bouncing button pins
//   btn_level   : debounced levels, 1 = pressed
//   btn_press   : one-cycle pulses when a level rises
//   btn_release : one-cycle pulses when a level falls
//   count       : CNT_WIDTH-bit up/down counter
//   count_limit : one-cycle pulse when a step wraps (SATURATE=0) or is
//                 blocked at a limit (SATURATE=1)
// count and count_limit update on the edge after the btn_press pulse.
// ---------------------------------------------------------------------------
module debounced_updown_counter
  import debounce_pkg::*;
#(
  parameter int unsigned NUM_BTNS      = 2,
  parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_12MHZ,
  parameter bit          ACTIVE_LOW    = BTN_ACTIVE_LOW,
  parameter int unsigned CNT_WIDTH     = 4,
  parameter bit          SATURATE      = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_BTNS-1:0]  btn_raw,
  output logic [NUM_BTNS-1:0]  btn_level,
  output logic [NUM_BTNS-1:0]  btn_press,
  output logic [NUM_BTNS-1:0]  btn_release,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 count_limit
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  for (genvar i = 0; i < NUM_BTNS; i++) begin : g_chan
    debounce_channel #(
      .STABLE_CYCLES(STABLE_CYCLES),
      .ACTIVE_LOW   (ACTIVE_LOW)
    ) u_chan (
      .clk        (clk),
      .rst        (rst),
      .btn_raw    (btn_raw[i]),
      .btn_level  (btn_level[i]),
      .btn_press  (btn_press[i]),
      .btn_release(btn_release[i])
    );
  end

  step_e step;

  // NOTE: step gets a default before the ifs, so every path assigns it and
  // no latch is inferred.
  always_comb begin
    step = STEP_HOLD;
    if (btn_press[0] && !btn_press[1]) begin
      step = STEP_UP;
    end else if (btn_press[1] && !btn_press[0]) begin
      step = STEP_DOWN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count       <= '0;
      count_limit <= 1'b0;
    end else begin
      count_limit <= 1'b0;
      unique case (step)
        STEP_UP: begin
          if (count == CNT_MAX) begin
            count_limit <= 1'b1;
            if (!SATURATE) count <= '0;
          end else begin
            count <= count + CNT_WIDTH'(1);
          end
        end
        STEP_DOWN: begin
          if (count == '0) begin
            count_limit <= 1'b1;
            if (!SATURATE) count <= CNT_MAX;
          end else begin
            count <= count - CNT_WIDTH'(1);
          end
        end
        default: begin
          // Both or neither pressed: hold.
        end
      endcase
    end
  end

endmodule

// File: tb/tb_debounced_updown_counter.sv
// ---------------------------------------------------------------------------
// tb_debounced_updown_counter
// Two DUTs (wrap and saturate) share clock, reset and raw buttons. Stimulus
// tasks push the hand-computed output events each DUT must show (cycle,
// levels, pulses, count, limit) into per-DUT queues; a monitor per DUT
// samples on the falling edge, and every observed event (any pulse, limit,
// level or count change) is popped and compared.
// ---------------------------------------------------------------------------
module tb_debounced_updown_counter;

  typedef struct packed {
    int         cyc;
    logic [1:0] level;
    logic [1:0] press;
    logic [1:0] rel;
    logic [3:0] count;
    logic       limit;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] btn_raw;

  logic [1:0] lvl_w, prs_w, rel_w, lvl_s, prs_s, rel_s;
  logic [3:0] cnt_w, cnt_s;
  logic       lim_w, lim_s;

  ev_t        q_w[$];
  ev_t        q_s[$];
  int         cyc = 0;
  int         tests_run = 0;
  int         tests_failed = 0;
  logic [3:0] cur_w, cur_s;   // count each DUT currently holds (hand-tracked)

  debounced_updown_counter #(
    .NUM_BTNS(2), .STABLE_CYCLES(8), .ACTIVE_LOW(1'b1), .CNT_WIDTH(4), .SATURATE(1'b0)
  ) dut_w (
    .clk(clk), .rst(rst), .btn_raw(btn_raw),
    .btn_level(lvl_w), .btn_press(prs_w), .btn_release(rel_w),
    .count(cnt_w), .count_limit(lim_w)
  );

  debounced_updown_counter #(
    .NUM_BTNS(2), .STABLE_CYCLES(8), .ACTIVE_LOW(1'b1), .CNT_WIDTH(4), .SATURATE(1'b1)
  ) dut_s (
    .clk(clk), .rst(rst), .btn_raw(btn_raw),
    .btn_level(lvl_s), .btn_press(prs_s), .btn_release(rel_s),
    .count(cnt_s), .count_limit(lim_s)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests_run=%0d", tests_run);
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic score(input string who, input ev_t got, input bit have, input ev_t exp);
    tests_run++;
    if (!have) begin
      tests_failed++;
      $display("FAIL %s unexpected_event: got cyc=%0d level=%b press=%b release=%b count=%0d limit=%b, required no event",
               who, got.cyc, got.level, got.press, got.rel, got.count, got.limit);
    end else if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s event: got cyc=%0d level=%b press=%b release=%b count=%0d limit=%b, required cyc=%0d level=%b press=%b release=%b count=%0d limit=%b",
               who, got.cyc, got.level, got.press, got.rel, got.count, got.limit,
               exp.cyc, exp.level, exp.press, exp.rel, exp.count, exp.limit);
    end
  endtask

  // Monitors: falling-edge sampling, ignored while reset is held.
  always @(negedge clk) begin : mon_w
    logic [1:0] prev_lvl;
    logic [3:0] prev_cnt;
    ev_t        got, exp;
    bit         have;
    if (rst !== 1'b0) begin
      prev_lvl = lvl_w;
      prev_cnt = cnt_w;
    end else if (prs_w != 2'b00 || rel_w != 2'b00 || lim_w || cnt_w != prev_cnt || lvl_w != prev_lvl) begin
      got  = '{cyc: cyc, level: lvl_w, press: prs_w, rel: rel_w, count: cnt_w, limit: lim_w};
      have = (q_w.size() > 0);
      exp  = have ? q_w.pop_front() : '0;
      score("wrap", got, have, exp);
      prev_lvl = lvl_w;
      prev_cnt = cnt_w;
    end
  end

  always @(negedge clk) begin : mon_s
    logic [1:0] prev_lvl;
    logic [3:0] prev_cnt;
    ev_t        got, exp;
    bit         have;
    if (rst !== 1'b0) begin
      prev_lvl = lvl_s;
      prev_cnt = cnt_s;
    end else if (prs_s != 2'b00 || rel_s != 2'b00 || lim_s || cnt_s != prev_cnt || lvl_s != prev_lvl) begin
      got  = '{cyc: cyc, level: lvl_s, press: prs_s, rel: rel_s, count: cnt_s, limit: lim_s};
      have = (q_s.size() > 0);
      exp  = have ? q_s.pop_front() : '0;
      score("sat", got, have, exp);
      prev_lvl = lvl_s;
      prev_cnt = cnt_s;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input bit sat, input int c, input logic [1:0] lv, input logic [1:0] pr,
                      input logic [1:0] rl, input logic [3:0] cn, input logic lm);
    ev_t e;
    e = '{cyc: c, level: lv, press: pr, rel: rl, count: cn, limit: lm};
    if (sat) q_s.push_back(e);
    else     q_w.push_back(e);
  endtask

  // Reset for 3 cycles, check every output is 0, release reset.
  task automatic do_reset(input string tag);
    rst = 1'b1;
    step(3);
    check({tag, "_reset_wrap"}, {21'd0, lvl_w, prs_w, rel_w, cnt_w, lim_w}, 32'd0);
    check({tag, "_reset_sat"},  {21'd0, lvl_s, prs_s, rel_s, cnt_s, lim_s}, 32'd0);
    rst   = 1'b0;
    cur_w = 4'd0;
    cur_s = 4'd0;
  endtask

  // Expectations for a press accepted 10 edges after the drive cycle c,
  // and the count step one edge later (only if something visible changes).
  task automatic expect_press(input int c, input logic [1:0] mask,
                              input logic [3:0] w_next, input logic w_lim,
                              input logic [3:0] s_next, input logic s_lim);
    push(1'b0, c + 10, mask, mask, 2'b00, cur_w, 1'b0);
    push(1'b1, c + 10, mask, mask, 2'b00, cur_s, 1'b0);
    if (w_next != cur_w || w_lim) push(1'b0, c + 11, mask, 2'b00, 2'b00, w_next, w_lim);
    if (s_next != cur_s || s_lim) push(1'b1, c + 11, mask, 2'b00, 2'b00, s_next, s_lim);
    cur_w = w_next;
    cur_s = s_next;
  endtask

  task automatic release_btn(input logic [1:0] mask);
    int c;
    c       = cyc;
    btn_raw = btn_raw | mask;
    push(1'b0, c + 10, 2'b00, 2'b00, mask, cur_w, 1'b0);
    push(1'b1, c + 10, 2'b00, 2'b00, mask, cur_s, 1'b0);
    step(12);
  endtask

  task automatic tap(input logic [1:0] mask,
                     input logic [3:0] w_next, input logic w_lim,
                     input logic [3:0] s_next, input logic s_lim);
    int c;
    c       = cyc;
    btn_raw = btn_raw & ~mask;
    expect_press(c, mask, w_next, w_lim, s_next, s_lim);
    step(12);
    release_btn(mask);
  endtask

  initial begin
    int c;
    rst     = 1'b1;
    btn_raw = 2'b11;
    do_reset("init");

    // Clean press on INC: 0 -> 1 in both modes.
    tap(2'b01, 4'd1, 1'b0, 4'd1, 1'b0);

    // Bounce: 3-cycle toggles never propagate; final low is accepted.
    do_reset("bounce");
    for (int i = 0; i < 14; i++) begin
      btn_raw[0] = (i % 2 == 0) ? 1'b0 : 1'b1;
      step(3);
    end
    c          = cyc;
    btn_raw[0] = 1'b0;
    expect_press(c, 2'b01, 4'd1, 1'b0, 4'd1, 1'b0);
    step(12);
    release_btn(2'b01);

    // DEC at 0: wrap -> 15 with limit, saturate holds 0 with limit.
    do_reset("dec0");
    tap(2'b10, 4'd15, 1'b1, 4'd0, 1'b1);

    // 15 INC presses, then a 16th at all-ones, then DEC.
    do_reset("inc16");
    for (int k = 1; k <= 15; k++) begin
      tap(2'b01, 4'(k), 1'b0, 4'(k), 1'b0);
    end
    tap(2'b01, 4'd0,  1'b1, 4'd15, 1'b1);
    tap(2'b10, 4'd15, 1'b1, 4'd14, 1'b0);

    // Simultaneous INC and DEC: both pulses, count held, no limit.
    do_reset("simul");
    tap(2'b11, 4'd0, 1'b0, 4'd0, 1'b0);

    // Reset at filter cycle 5 of a held press; press restarts from reset exit.
    do_reset("midfilt_a");
    btn_raw[0] = 1'b0;
    step(7);
    do_reset("midfilt_b");
    c = cyc;
    expect_press(c, 2'b01, 4'd1, 1'b0, 4'd1, 1'b0);
    step(12);
    release_btn(2'b01);

    step(5);
    check("wrap_queue_drained", 32'(q_w.size()), 32'd0);
    check("sat_queue_drained",  32'(q_s.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
